serial_adder_ctrl: RTL
======================

Name: serial_adder_ctrl

Overview:
- Bit-serial N-bit adder controller built around one instance of the team's 1-bit full_adder cell.
- Accepts two WIDTH-bit operands and a carry-in on a start pulse.
- Sequences the single full_adder LSB-first over WIDTH cycles, holding the carry in a flop between bits.
- Presents the WIDTH-bit sum and carry-out with a one-cycle done pulse. Serves as the area-minimal adder for slow datapaths.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to begin an add; sampled only in IDLE.
- a_in  input  WIDTH  operand A; captured on the accepting edge.
- b_in  input  WIDTH  operand B; captured on the accepting edge.
- cin_in  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while in RUN or DONE.
- done  output  1  one-cycle pulse; result valid.
- sum_out  output  WIDTH  registered sum; held until the next completion.
- cout_out  output  1  registered carry-out; held until the next completion.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset: state=IDLE, busy=0, done=0, sum_out=0, cout_out=0, operand shift regs=0, carry flop=0, bit counter=0. Reset has priority over every other input, including start on the same edge.
- States: IDLE, RUN, DONE. busy=1 in RUN and DONE; done=1 only in DONE (Moore outputs).
- IDLE:
  - On an edge with start=1: a_sr<=a_in, b_sr<=b_in, carry<=cin_in, cnt<=0, sum_sr<=0, go to RUN.
  - With start=0: stay in IDLE.
- RUN:
  - full_adder inputs: a_sr[0], b_sr[0], carry.
  - Each edge: a_sr and b_sr shift right by 1 (zero fill); sum_sr shifts right with the full_adder sum entering at MSB; carry<=full_adder cout; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1: sum_out<=shifted sum_sr (the final value including this bit), cout_out<=full_adder cout, go to DONE.
- DONE: one cycle with done=1, then unconditionally to IDLE.
- Latency: start sampled at edge E; done high in the cycle following edge E+WIDTH; busy falls at edge E+WIDTH+1. Throughput: one add per WIDTH+2 cycles.
- start while busy (RUN or DONE) is ignored; it is neither queued nor allowed to corrupt the in-flight operation.
- a_in, b_in and cin_in changing after the accepting edge have no effect.
- sum_out and cout_out change only on the edge entering DONE (or on reset); they are stable at all other times.
- Reset mid-RUN: aborts the operation; outputs return to reset values on that edge; no done pulse is produced.
- Counter width: $clog2(WIDTH)+1 bits. For WIDTH=1, RUN lasts exactly one edge.
- Arithmetic: result = (a_in + b_in + cin_in) mod 2^WIDTH; cout_out is bit WIDTH of the full sum.

Optional Feature:
- Macro SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured with the operands.
  - When sub=1: b_sr loads ~b_in and carry loads 1 (cin_in ignored). Result is a_in - b_in mod 2^WIDTH; cout_out=1 means no borrow.
  - When sub=0: behaviour is identical to the base block.
- Undefined: no sub port exists; the block only adds.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, cin=0, start pulse -> done exactly 9 cycles after the accepting edge; sum_out=0x96, cout_out=0; busy high for 9 cycles.
- a=0xFF, b=0x01, cin=0 -> sum_out=0x00, cout_out=1. Then a=0xFF, b=0xFF, cin=1 -> sum_out=0xFF, cout_out=1.
- Start an add of 0x12+0x34. Hold start=1 and change a_in/b_in to 0xAA/0x55 during RUN -> first result is 0x46 with a single done pulse. The held start is then accepted in IDLE, giving 0xFF on the next done.
- Assert reset 3 cycles into RUN -> busy=0, done=0, sum_out=0x00, cout_out=0 on that edge; no done pulse follows. A later add 0x01+0x01 gives 0x02.
- WIDTH=4 exhaustive: all 512 (a,b,cin) combinations -> {cout_out,sum_out}==a+b+cin each time; done 5 cycles after each accept.
- With SERIAL_ADDER_SUB_EN, WIDTH=8: 0x10-0x01 -> sum_out=0x0F, cout_out=1; 0x00-0x01 -> sum_out=0xFF, cout_out=0.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full_adder cell sequenced LSB-first, carry held in a flop.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN (adds the 'sub' port).

module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d, sum_q, sum_d;
    logic             c_q, c_d, cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_s, fa_co;
    logic [WIDTH-1:0] b_ld;
    logic             c_ld;
    logic [WIDTH:0]   s_shift;

    full_adder u_fa (
        .a_i  (a_q[0]),
        .b_i  (b_q[0]),
        .ci_i (c_q),
        .s_o  (fa_s),
        .co_o (fa_co)
    );

`ifdef SERIAL_ADDER_SUB_EN
    // Two's-complement subtract: invert B and force the carry-in.
    assign b_ld = sub ? ~b_in : b_in;
    assign c_ld = sub ? 1'b1  : cin_in;
`else
    assign b_ld = b_in;
    assign c_ld = cin_in;
`endif

    // New sum bit enters at the MSB; written this way so WIDTH=1 needs no empty slice.
    assign s_shift = {fa_s, s_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_ld;
                    c_d     = c_ld;
                    cnt_d   = '0;
                    s_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                s_d   = s_shift[WIDTH:1];
                c_d   = fa_co;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = s_shift[WIDTH:1];
                    cout_d  = fa_co;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign sum_out  = sum_q;
    assign cout_out = cout_q;
endmodule
